instr_issue_scheduler: RTL and testbench
========================================

# instr_issue_scheduler

In-order fetch-and-issue controller for the 4-bit-nibble instruction memory used by the dependency-check datapath. It walks the memory by address, assembles each 4-nibble instruction (opcode, rd, rs1, rs2) and tracks pending writes in a per-register countdown scoreboard. It stalls on RAW, WAW and structural (shared MUL/DIV unit) hazards and issues one instruction at a time to the execution units. It sits between the instruction memory and the ALU/MDU issue ports, and stops at the END opcode.

## Interface
- NUM_REGS, 8: architectural registers; register fields are 4 bits, values >= NUM_REGS are illegal
- LAT_ALU, 1: ADD/SUB result latency in cycles (pipelined ALU)
- LAT_MUL, 4: MUL latency (shared non-pipelined MDU)
- LAT_DIV, 8: DIV latency (shared MDU)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a run at address 0 when in IDLE or DONE
- mem_addr  out  6  nibble address to instruction memory
- mem_data  in  4  combinational read data for mem_addr, sampled the same cycle
- issue_valid  out  1  one-cycle pulse per issued instruction
- issue_op  out  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV
- issue_rd, issue_rs1, issue_rs2  out  4 each  register fields, valid with issue_valid
- hazard  out  2  0 none, 1 RAW, 2 WAW, 3 structural; valid in CHECK
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high while in DONE
- error  out  1  set on illegal opcode, illegal register or address wrap; cleared by start or rst
- instr_count  out  5  instructions issued this run
- stall_count  out  16  CHECK cycles spent stalled this run, saturating at 0xFFFF

## Operation
- FSM states: IDLE, FETCH, CHECK, DRAIN, DONE.
- IDLE: on start go to FETCH. Clear addr, field index, counters, error and scoreboard.
- FETCH: each cycle latch mem_data into field[idx], then increment addr and idx.
  - idx 0 with value 4 (END): go to DRAIN.
  - idx 0 with value 5..15: set error, go to DONE.
  - After idx 3: go to CHECK.
- CHECK:
  - Hazard terms:
    - RAW = sb[rs1]!=0 or sb[rs2]!=0
    - WAW = sb[rd]!=0
    - STRUCT = op is MUL/DIV and mdu_cnt!=0
  - Priority RAW > WAW > STRUCT. hazard reports the highest active term.
  - Any hazard: stay in CHECK and increment stall_count.
  - No hazard: pulse issue_valid, load sb[rd] with the op latency, load mdu_cnt with LAT_MUL or LAT_DIV for MUL/DIV, increment instr_count, go to FETCH.
  - Any register field >= NUM_REGS: set error, go to DONE, nothing issued.
- WAR cannot occur: operands are read at issue, in order.
- rd equal to rs1 or rs2 is legal. The check uses the pre-issue scoreboard.
- Scoreboard: each sb entry and mdu_cnt decrements by 1 on every edge while nonzero. This includes edges where another entry is loaded. A load overrides the decrement for that entry.
- DRAIN: wait until all sb entries and mdu_cnt are zero, then go to DONE.
- DONE: hold done and the counters. start restarts exactly as from IDLE.
- Address wrap: if addr would wrap from 63 to 0 without END, set error and go to DONE.
- rst in any state returns to IDLE next edge and clears everything, including mid-stall and mid-DRAIN.

## Timing
- Reset values:
  - mem_addr, issue_*, hazard, instr_count, stall_count: 0
  - busy, done, error: 0
  - state: IDLE
- start sampled at edge 0. FETCH occupies cycles 1–4; the first CHECK is cycle 5.
- Unstalled cost is 5 cycles per instruction.
- An entry loaded with LAT at issue cycle T reads LAT during T+1 and 0 during T+LAT+1.
- The next CHECK is at T+5, so a dependent instruction stalls max(0, LAT−4) cycles.
- Defaults: ALU and MUL dependences never stall; a DIV dependence stalls 4 cycles.
- issue_* hold their last values between pulses.
- The cycle after an END fetch enters DRAIN. done rises the cycle after the scoreboard is all zero.

## Structure
- Shared package isa_pkg:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_END=4
  - hazard codes
  - FSM state enum
  - instruction field typedef (4×4 bits)
- Sub-module reg_scoreboard: NUM_REGS countdown entries plus mdu_cnt. It has load, read and all_zero ports. The FSM, fetch and counters stay in the top module.

## Test plan
- Reset: assert rst 2 cycles, including mid-run. All outputs 0, state IDLE; start then fetches from address 0.
- Independent ops: ADD R1,R2,R3; SUB R4,R5,R6; END.
  - issue_valid at cycles 5 and 10.
  - hazard stays 0; instr_count=2, stall_count=0.
  - done at cycle 13.
- RAW: DIV R6,R5,R4; ADD R7,R6,R1; END.
  - ADD reports hazard=1 for 4 cycles and issues at cycle 14.
  - stall_count=4.
- WAW and structural:
  - DIV R3,R1,R2; ADD R3,R4,R5: hazard=2, 4 stalls.
  - DIV R1,R2,R3; MUL R4,R5,R6: hazard=3, 4 stalls.
  - RAW-over-WAW priority: a case with both active reports 1.
- Errors, each ending with done=1, error=1:
  - opcode 9 at address 4, after one issue.
  - rd=12.
  - 16 valid instructions with no END (address wrap).
- Restart from DONE: start again. Counters clear and the same program repeats with identical issue cycles.

Source files
------------

// File: rtl/instr_issue_scheduler_pkg.sv
// isa_pkg: opcodes, hazard codes, FSM states and instruction layout shared by the issue scheduler
package isa_pkg;
  localparam int NUM_REGS = 8;
  localparam int LAT_ALU = 1;
  localparam int LAT_MUL = 4;
  localparam int LAT_DIV = 8;
  localparam int REG_W = $clog2(NUM_REGS);
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_END = 4'd4;
  localparam int F_OP = 0;
  localparam int F_RD = 1;
  localparam int F_RS1 = 2;
  localparam int F_RS2 = 3;
  typedef logic [3:0] lat_t;
  typedef logic [0:3][3:0] instr_t;
  typedef enum logic [1:0] {HZ_NONE, HZ_RAW, HZ_WAW, HZ_STRUCT} hazard_t;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/instr_issue_scheduler_if.sv
// instr_issue_scheduler_if: instruction memory, issue port and status bundle
interface instr_issue_scheduler_if;
  logic start;
  logic [5:0] mem_addr;
  logic [3:0] mem_data;
  logic issue_valid;
  logic [2:0] issue_op;
  logic [3:0] issue_rd;
  logic [3:0] issue_rs1;
  logic [3:0] issue_rs2;
  logic [1:0] hazard;
  logic busy;
  logic done;
  logic error;
  logic [4:0] instr_count;
  logic [15:0] stall_count;
  modport master (
    input start, mem_data,
    output mem_addr, issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
    output hazard, busy, done, error, instr_count, stall_count
  );
  modport slave (
    output start, mem_data,
    input mem_addr, issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2,
    input hazard, busy, done, error, instr_count, stall_count
  );
endinterface

// File: rtl/instr_issue_scheduler_reg_scoreboard.sv
// reg_scoreboard: per-register and shared-MDU countdown timers of pending results
module reg_scoreboard
  import isa_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       ld,
  input  logic [REG_W-1:0]           ld_idx,
  input  lat_t                       ld_lat,
  input  logic                       ld_mdu,
  input  logic [2:0][REG_W-1:0]      rd_idx,
  output logic [2:0]                 pending,
  output logic                       mdu_busy,
  output logic                       all_zero
);
  lat_t [NUM_REGS-1:0] sb_q, sb_d;
  lat_t mdu_q, mdu_d;
  assign mdu_busy = mdu_q != '0;
  always_comb begin
    mdu_d = clr ? '0 : ld && ld_mdu ? ld_lat : mdu_q - lat_t'(mdu_q != '0);
    all_zero = mdu_q == '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      sb_d[i] = clr ? '0 : ld && ld_idx == REG_W'(i) ? ld_lat : sb_q[i] - lat_t'(sb_q[i] != '0);
      all_zero = all_zero && sb_q[i] == '0;
    end
    for (int i = 0; i < 3; i++) pending[i] = sb_q[rd_idx[i]] != '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
      mdu_q <= '0;
    end else begin
      sb_q <= sb_d;
      mdu_q <= mdu_d;
    end
  end
endmodule

// File: rtl/instr_issue_scheduler.sv
// instr_issue_scheduler: in-order nibble fetch, hazard check and single issue with run counters
module instr_issue_scheduler
  import isa_pkg::*;
(
  input logic clk,
  input logic rst,
  instr_issue_scheduler_if.master bus
);
  state_t state_q, state_d;
  logic [5:0] addr_q, addr_d;
  logic [1:0] idx_q, idx_d;
  instr_t ins_q, ins_d;
  logic [2:0] op_q, op_d;
  logic [0:2][3:0] iss_q, iss_d;
  logic [4:0] icnt_q, icnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic err_q, err_d, clr, issue, illegal, is_mdu, mdu_busy, all_zero;
  logic [2:0] pend;
  hazard_t hz;
  lat_t lat;
  assign illegal = !(ins_q[F_OP] inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV}) || ins_q[F_RD] >= 4'(NUM_REGS)
                   || ins_q[F_RS1] >= 4'(NUM_REGS) || ins_q[F_RS2] >= 4'(NUM_REGS);
  assign is_mdu = ins_q[F_OP] == OP_MUL || ins_q[F_OP] == OP_DIV;
  assign lat = ins_q[F_OP] == OP_DIV ? lat_t'(LAT_DIV) : is_mdu ? lat_t'(LAT_MUL) : lat_t'(LAT_ALU);
  assign hz = state_q != S_CHECK || illegal ? HZ_NONE : pend[1] || pend[0] ? HZ_RAW :
              pend[2] ? HZ_WAW : is_mdu && mdu_busy ? HZ_STRUCT : HZ_NONE;
  assign issue = state_q == S_CHECK && !illegal && hz == HZ_NONE;
  reg_scoreboard u_sb (
    .clk(clk), .rst(rst), .clr(clr), .ld(issue), .ld_idx(ins_q[F_RD][REG_W-1:0]), .ld_lat(lat),
    .ld_mdu(is_mdu),
    .rd_idx({ins_q[F_RD][REG_W-1:0], ins_q[F_RS1][REG_W-1:0], ins_q[F_RS2][REG_W-1:0]}),
    .pending(pend), .mdu_busy(mdu_busy), .all_zero(all_zero)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    idx_d = idx_q;
    ins_d = ins_q;
    op_d = op_q;
    iss_d = iss_q;
    icnt_d = icnt_q;
    scnt_d = scnt_q;
    err_d = err_q;
    clr = 1'b0;
    if ((state_q == S_IDLE || state_q == S_DONE) && bus.start) begin
      state_d = S_FETCH;
      addr_d = '0;
      idx_d = '0;
      icnt_d = '0;
      scnt_d = '0;
      err_d = 1'b0;
      clr = 1'b1;
    end else if (state_q == S_FETCH) begin
      ins_d[idx_q] = bus.mem_data;
      addr_d = addr_q + 6'd1;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd0 && bus.mem_data == OP_END) state_d = S_DRAIN;
      else if ((idx_q == 2'd0 && bus.mem_data > OP_END) || addr_q == 6'd63) begin
        err_d = 1'b1;
        state_d = S_DONE;
      end else if (idx_q == 2'd3) state_d = S_CHECK;
    end else if (state_q == S_CHECK) begin
      if (illegal) begin
        err_d = 1'b1;
        state_d = S_DONE;
      end else if (hz != HZ_NONE) scnt_d = scnt_q + {15'd0, ~&scnt_q};
      else begin
        state_d = S_FETCH;
        icnt_d = icnt_q + 5'd1;
        op_d = ins_q[F_OP][2:0];
        iss_d = ins_q[F_RD:F_RS2];
      end
    end else if (state_q == S_DRAIN && all_zero) state_d = S_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      idx_q <= '0;
      ins_q <= '0;
      op_q <= '0;
      iss_q <= '0;
      icnt_q <= '0;
      scnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      idx_q <= idx_d;
      ins_q <= ins_d;
      op_q <= op_d;
      iss_q <= iss_d;
      icnt_q <= icnt_d;
      scnt_q <= scnt_d;
      err_q <= err_d;
    end
  end
  assign bus.mem_addr = addr_q;
  assign bus.issue_valid = issue;
  assign bus.issue_op = issue ? ins_q[F_OP][2:0] : op_q;
  assign bus.issue_rd = issue ? ins_q[F_RD] : iss_q[0];
  assign bus.issue_rs1 = issue ? ins_q[F_RS1] : iss_q[1];
  assign bus.issue_rs2 = issue ? ins_q[F_RS2] : iss_q[2];
  assign bus.hazard = hz;
  assign bus.busy = state_q != S_IDLE && state_q != S_DONE;
  assign bus.done = state_q == S_DONE;
  assign bus.error = err_q;
  assign bus.instr_count = icnt_q;
  assign bus.stall_count = scnt_q;
endmodule

// File: tb/tb_instr_issue_scheduler.sv
// tb_instr_issue_scheduler: directed vector table plus random programs checked against a cycle-timing model
module tb_instr_issue_scheduler;
  import isa_pkg::*;
  localparam int MAXC = 2048;
  typedef struct packed {
    logic [0:3][15:0] prog;
    logic wrap;
    int icnt;
    int scnt;
    int done_c;
    logic err;
    int haz;
    int iss2;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] mem [64];
  int n_cmp = 0;
  int n_fail = 0;
  bit m_valid [MAXC];
  int m_haz [MAXC];
  logic [15:0] m_ins [MAXC];
  int m_done, m_icnt, m_scnt;
  logic m_err;
  vec_t vecs [8];
  instr_issue_scheduler_if bus();
  instr_issue_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.mem_data = mem[bus.mem_addr];
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
    end
  endtask
  function automatic int mx(input int x, input int y);
    return x > y ? x : y;
  endfunction
  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_valid"}, bus.issue_valid, 0);
    chk({tag, "_fields"}, {bus.issue_op, bus.issue_rd, bus.issue_rs1, bus.issue_rs2}, 0);
    chk({tag, "_hazard"}, bus.hazard, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_error"}, bus.error, 0);
    chk({tag, "_icnt"}, bus.instr_count, 0);
    chk({tag, "_scnt"}, bus.stall_count, 0);
  endtask
  task automatic load_vec(input vec_t v);
    for (int a = 0; a < 64; a++) mem[a] = v.wrap ? 4'(a % 4) : 4'h4;
    if (!v.wrap)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) mem[4*i+j] = v.prog[i][15-4*j -: 4];
  endtask
  // Timing model: a register is free from cycle issue+lat+1; an instruction fetched from cycle t is checked at t+4.
  task automatic model();
    int t = 1, a = 0, mf = 0, c, iss, rr, ww, ss, lat, f;
    int fr [8];
    logic [3:0] op, rd, r1, r2;
    for (int x = 0; x < MAXC; x++) begin
      m_valid[x] = 0;
      m_haz[x] = 0;
      m_ins[x] = '0;
    end
    for (int x = 0; x < 8; x++) fr[x] = 0;
    m_err = 0;
    m_icnt = 0;
    m_scnt = 0;
    m_done = -1;
    while (1) begin
      op = mem[a];
      if (op == 4'd4) begin
        f = mx(t + 1, mf);
        for (int x = 0; x < 8; x++) f = mx(f, fr[x]);
        m_done = f + 1;
        break;
      end
      if (op > 4'd4) begin
        m_err = 1;
        m_done = t + 1;
        break;
      end
      if (a == 60) begin
        m_err = 1;
        m_done = t + 4;
        break;
      end
      rd = mem[a+1];
      r1 = mem[a+2];
      r2 = mem[a+3];
      c = t + 4;
      if (rd > 7 || r1 > 7 || r2 > 7) begin
        m_err = 1;
        m_done = c + 1;
        break;
      end
      rr = mx(fr[r1[2:0]], fr[r2[2:0]]);
      ww = fr[rd[2:0]];
      ss = op >= 2 ? mf : 0;
      iss = mx(mx(c, rr), mx(ww, ss));
      for (int x = c; x < iss; x++) m_haz[x] = x < rr ? 1 : x < ww ? 2 : 3;
      m_scnt += iss - c;
      m_valid[iss] = 1;
      m_ins[iss] = {op, rd, r1, r2};
      lat = op == 3 ? LAT_DIV : op == 2 ? LAT_MUL : LAT_ALU;
      fr[rd[2:0]] = iss + lat + 1;
      if (op >= 2) mf = iss + lat + 1;
      m_icnt++;
      t = iss + 1;
      a += 4;
    end
  endtask
  task automatic run(input bit use_model, output int done_c, output int first_haz, output int iss2);
    int cyc = 1, n_iss = 0;
    done_c = -1;
    first_haz = 0;
    iss2 = 0;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
    chk("start_icnt", bus.instr_count, 0);
    chk("start_scnt", bus.stall_count, 0);
    chk("start_error", bus.error, 0);
    chk("start_addr", bus.mem_addr, 0);
    while (cyc < MAXC) begin
      if (bus.issue_valid) begin
        n_iss++;
        if (n_iss == 2) iss2 = cyc;
      end
      if (first_haz == 0) first_haz = int'(bus.hazard);
      if (use_model) begin
        chk($sformatf("valid@%0d", cyc), bus.issue_valid, m_valid[cyc]);
        chk($sformatf("hazard@%0d", cyc), bus.hazard, m_haz[cyc]);
        if (m_valid[cyc])
          chk($sformatf("fields@%0d", cyc), {1'b0, bus.issue_op, bus.issue_rd, bus.issue_rs1, bus.issue_rs2}, m_ins[cyc]);
      end
      if (bus.done) begin
        done_c = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    int d, h, s2, n;
    vecs[0] = '{prog: {16'h0123, 16'h1456, 16'h4000, 16'h0}, wrap: 0, icnt: 2, scnt: 0, done_c: 13, err: 0, haz: 0, iss2: 10};
    vecs[1] = '{prog: {16'h3654, 16'h0761, 16'h4000, 16'h0}, wrap: 0, icnt: 2, scnt: 4, done_c: 17, err: 0, haz: 1, iss2: 14};
    vecs[2] = '{prog: {16'h3312, 16'h0345, 16'h4000, 16'h0}, wrap: 0, icnt: 2, scnt: 4, done_c: 17, err: 0, haz: 2, iss2: 14};
    vecs[3] = '{prog: {16'h3123, 16'h2456, 16'h4000, 16'h0}, wrap: 0, icnt: 2, scnt: 4, done_c: 20, err: 0, haz: 3, iss2: 14};
    vecs[4] = '{prog: {16'h3123, 16'h0112, 16'h4000, 16'h0}, wrap: 0, icnt: 2, scnt: 4, done_c: 17, err: 0, haz: 1, iss2: 14};
    vecs[5] = '{prog: {16'h0123, 16'h9000, 16'h4000, 16'h0}, wrap: 0, icnt: 1, scnt: 0, done_c: 7, err: 1, haz: 0, iss2: 0};
    vecs[6] = '{prog: {16'h0C12, 16'h4000, 16'h0, 16'h0}, wrap: 0, icnt: 0, scnt: 0, done_c: 6, err: 1, haz: 0, iss2: 0};
    vecs[7] = '{prog: '0, wrap: 1, icnt: -1, scnt: 0, done_c: 80, err: 1, haz: 0, iss2: 10};
    bus.start = 1'b0;
    for (int a = 0; a < 64; a++) mem[a] = 4'h4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    for (int rep = 0; rep < 2; rep++)
      for (int i = 0; i < 8; i++) begin
        load_vec(vecs[i]);
        run(1'b0, d, h, s2);
        chk($sformatf("v%0d_done_cycle", i), d, vecs[i].done_c);
        chk($sformatf("v%0d_first_hazard", i), h, vecs[i].haz);
        chk($sformatf("v%0d_issue2_cycle", i), s2, vecs[i].iss2);
        chk($sformatf("v%0d_stall_count", i), bus.stall_count, vecs[i].scnt);
        chk($sformatf("v%0d_error", i), bus.error, vecs[i].err);
        chk($sformatf("v%0d_done", i), bus.done, 1);
        if (vecs[i].icnt >= 0) chk($sformatf("v%0d_instr_count", i), bus.instr_count, vecs[i].icnt);
      end
    load_vec(vecs[1]);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    repeat (9) @(negedge clk);
    chk("midrun_stall_hazard", bus.hazard, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("midrun_reset");
    rst = 1'b0;
    load_vec(vecs[0]);
    run(1'b0, d, h, s2);
    chk("after_reset_done_cycle", d, 13);
    chk("after_reset_issue2_cycle", s2, 10);
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 8);
      for (int a = 0; a < 64; a++) mem[a] = 4'h4;
      for (int k = 0; k < n; k++) begin
        mem[4*k] = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 3));
        for (int j = 1; j < 4; j++)
          mem[4*k+j] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 3));
      end
      model();
      run(1'b1, d, h, s2);
      chk($sformatf("rand%0d_done_cycle", r), d, m_done);
      chk($sformatf("rand%0d_instr_count", r), bus.instr_count, m_icnt);
      chk($sformatf("rand%0d_stall_count", r), bus.stall_count, m_scnt);
      chk($sformatf("rand%0d_error", r), bus.error, m_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
